tqv_gpio_irq: RTL

Parametrised GPIO and interrupt controller that sits on the tinyQV peripheral data bus alongside the UART and SPI blocks. It generalises the fixed 8-bit GPIO_OUT / GPIO_IN / GPIO_OUT_SEL registers to WIDTH pins and adds the following:
- configurable input synchronisation depth;
- per-pin interrupt detection (level-high, rising, falling or both edges) with sticky pending bits;
- an interrupt mask;
- atomic set/clear/toggle of outputs.

The top level decodes the peripheral window and drives `sel`. This block returns `irq` into the `interrupt_req` vector.

---
 rtl/tqv_gpio_irq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tqv_gpio_irq.sv
// GPIO and interrupt controller for the tinyQV peripheral bus: OUT/IN/OUT_SEL
// registers, per-pin edge/level interrupt detection with sticky pending bits.
module tqv_gpio_irq #(
    parameter int               WIDTH         = 8,
    parameter int               SYNC_STAGES   = 2,
    parameter logic [WIDTH-1:0] OUT_SEL_RESET = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sel,
    input  logic [3:0]       addr,
    input  logic [1:0]       write_n,
    input  logic [1:0]       read_n,
    input  logic [31:0]      data_in,
    output logic [31:0]      data_out,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_out_sel,
    output logic             irq
);

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'b00,
        MODE_RISE  = 2'b01,
        MODE_FALL  = 2'b10,
        MODE_BOTH  = 2'b11
    } mode_e;

    localparam logic [3:0] ADDR_OUT     = 4'd0;
    localparam logic [3:0] ADDR_IN      = 4'd1;
    localparam logic [3:0] ADDR_OUT_SEL = 4'd2;
    localparam logic [3:0] ADDR_MODE    = 4'd3;
    localparam logic [3:0] ADDR_ENABLE  = 4'd4;
    localparam logic [3:0] ADDR_PENDING = 4'd5;
    localparam logic [3:0] ADDR_SET     = 4'd6;
    localparam logic [3:0] ADDR_CLR     = 4'd7;
    localparam logic [3:0] ADDR_TOGGLE  = 4'd8;

    localparam logic [2:0] GUARD_DONE = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   out_sel_q, out_sel_d;
    logic [2*WIDTH-1:0] mode_q, mode_d;
    logic [WIDTH-1:0]   enable_q, enable_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [WIDTH-1:0]   sync_chain_q [SYNC_STAGES];
    logic [WIDTH-1:0]   prev_q;
    logic [2:0]         guard_q, guard_d;
    logic               irq_q;

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] rise, fall, set_cond, w1c_clr;
    logic             wr_en, edge_en;
    logic [31:0]      wmask, wdata;

    logic unused_read_n;
    assign unused_read_n = ^read_n;

    assign sync_q  = sync_chain_q[SYNC_STAGES-1];
    assign edge_en = (guard_q == GUARD_DONE);
    assign rise    = edge_en ? (sync_q & ~prev_q) : '0;
    assign fall    = edge_en ? (~sync_q & prev_q) : '0;
    assign guard_d = edge_en ? guard_q : guard_q + 3'd1;

    assign wr_en = sel && (write_n != 2'b11);
    assign wdata = data_in & wmask;

    always_comb begin
        case (write_n)
            2'b00:   wmask = 32'h0000_00FF;
            2'b01:   wmask = 32'h0000_FFFF;
            2'b10:   wmask = 32'hFFFF_FFFF;
            default: wmask = 32'h0000_0000;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        set_cond = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode_e'(mode_q[2*i +: 2]))
                MODE_LEVEL: set_cond[i] = sync_q[i];
                MODE_RISE:  set_cond[i] = rise[i];
                MODE_FALL:  set_cond[i] = fall[i];
                default:    set_cond[i] = rise[i] | fall[i];
            endcase
        end
    end

    always_comb begin
        out_d     = out_q;
        out_sel_d = out_sel_q;
        mode_d    = mode_q;
        enable_d  = enable_q;
        w1c_clr   = '0;
        if (wr_en) begin
            case (addr)
                ADDR_OUT:     out_d     = WIDTH'((32'(out_q) & ~wmask) | wdata);
                ADDR_OUT_SEL: out_sel_d = WIDTH'((32'(out_sel_q) & ~wmask) | wdata);
                ADDR_MODE:    mode_d    = (2*WIDTH)'((32'(mode_q) & ~wmask) | wdata);
                ADDR_ENABLE:  enable_d  = WIDTH'((32'(enable_q) & ~wmask) | wdata);
                ADDR_PENDING: w1c_clr   = WIDTH'(wdata);
                ADDR_SET:     out_d     = out_q | WIDTH'(wdata);
                ADDR_CLR:     out_d     = out_q & ~WIDTH'(wdata);
                ADDR_TOGGLE:  out_d     = out_q ^ WIDTH'(wdata);
                default:      ;
            endcase
        end
        // A new set condition overrides a simultaneous W1C of the same bit.
        pending_d = (pending_q & ~w1c_clr) | set_cond;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q     <= '0;
            out_sel_q <= OUT_SEL_RESET;
            mode_q    <= '0;
            enable_q  <= '0;
            pending_q <= '0;
            prev_q    <= '0;
            guard_q   <= '0;
            irq_q     <= 1'b0;
            // NOTE: the synchroniser is a handful of flops, not a RAM, so it is reset like any other state.
            for (int s = 0; s < SYNC_STAGES; s++) sync_chain_q[s] <= '0;
        end else begin
            out_q     <= out_d;
            out_sel_q <= out_sel_d;
            mode_q    <= mode_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
            prev_q    <= sync_q;
            guard_q   <= guard_d;
            irq_q     <= |(pending_q & enable_q);
            sync_chain_q[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_chain_q[s] <= sync_chain_q[s-1];
        end
    end

    always_comb begin
        data_out = '0;
        if (sel) begin
            case (addr)
                ADDR_OUT:     data_out = 32'(out_q);
                ADDR_IN:      data_out = 32'(sync_q);
                ADDR_OUT_SEL: data_out = 32'(out_sel_q);
                ADDR_MODE:    data_out = 32'(mode_q);
                ADDR_ENABLE:  data_out = 32'(enable_q);
                ADDR_PENDING: data_out = 32'(pending_q);
                ADDR_SET, ADDR_CLR, ADDR_TOGGLE: data_out = '0;
                default:      data_out = 32'hFFFF_FFFF;
            endcase
        end
    end

    assign gpio_out     = out_q;
    assign gpio_out_sel = out_sel_q;
    assign irq          = irq_q;

endmodule
